// File: rtl/led_frame_ctrl.sv
// Double-buffered row-pattern store for led_mux: producer fills a shadow bank,
// commit swaps banks on a frame boundary, then the new active image is copied back.
module led_frame_ctrl #(
    parameter int NUM_ROWS       = 4,
    parameter int NUM_ROWS_WIDTH = 2,
    parameter int NUM_COLS       = 8
) (
    input  logic                         clk,
    input  logic                         i_rst,
    input  logic                         i_wr_valid,
    output logic                         o_wr_ready,
    input  logic [NUM_ROWS_WIDTH-1:0]    i_wr_row,
    input  logic [NUM_COLS-1:0]          i_wr_data,
    output logic                         o_wr_err,
    input  logic                         i_commit,
    output logic                         o_commit_pending,
    input  logic                         i_frame_sync,
    output logic                         o_swap,
    output logic [NUM_ROWS*NUM_COLS-1:0] o_rows
);

    // Write port: a row is taken on any edge where i_wr_valid && o_wr_ready.
    // The producer holds i_wr_valid, i_wr_row and i_wr_data until then.

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_COPY    = 2'd2
    } state_t;

    localparam logic [NUM_ROWS_WIDTH:0]   LP_ROWS = (NUM_ROWS_WIDTH+1)'(NUM_ROWS);
    localparam logic [NUM_ROWS_WIDTH-1:0] LP_LAST = NUM_ROWS_WIDTH'(NUM_ROWS - 1);

    state_t                         r_state;
    logic                           r_bank_sel;
    logic [NUM_COLS-1:0]            r_bank [0:1][0:NUM_ROWS-1];
    logic [NUM_ROWS_WIDTH-1:0]      r_copy_idx;
    logic                           r_wr_ready;
    logic                           r_wr_err;
    logic                           r_pending;
    logic                           r_swap;
    logic [NUM_ROWS*NUM_COLS-1:0]   r_rows;

    logic w_accept;
    logic w_row_ok;

    assign w_accept = i_wr_valid && r_wr_ready;
    assign w_row_ok = ({1'b0, i_wr_row} < LP_ROWS);

    always_ff @(posedge clk) begin
        if (!i_rst) begin
            r_state    <= ST_IDLE;
            r_bank_sel <= 1'b0;
            r_copy_idx <= '0;
            r_wr_ready <= 1'b0;
            r_wr_err   <= 1'b0;
            r_pending  <= 1'b0;
            r_swap     <= 1'b0;
            r_rows     <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < NUM_ROWS; r++) begin
                    r_bank[b][r] <= '0;
                end
            end
        end else begin
            r_swap   <= 1'b0;
            r_wr_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_wr_ready <= 1'b1;
                    if (w_accept) begin
                        if (w_row_ok) begin
                            for (int r = 0; r < NUM_ROWS; r++) begin
                                if (i_wr_row == NUM_ROWS_WIDTH'(r)) begin
                                    r_bank[~r_bank_sel][r] <= i_wr_data;
                                end
                            end
                        end else begin
                            r_wr_err <= 1'b1;
                        end
                    end
                    // Commit is only honoured once the write port is open, so a
                    // same-cycle write always lands before the frame is frozen.
                    if (r_wr_ready && i_commit) begin
                        r_state    <= ST_PENDING;
                        r_pending  <= 1'b1;
                        r_wr_ready <= 1'b0;
                    end
                end
                ST_PENDING: begin
                    if (i_frame_sync) begin
                        r_state    <= ST_COPY;
                        r_bank_sel <= ~r_bank_sel;
                        r_pending  <= 1'b0;
                        r_swap     <= 1'b1;
                        r_copy_idx <= '0;
                        for (int r = 0; r < NUM_ROWS; r++) begin
                            r_rows[r*NUM_COLS +: NUM_COLS] <= r_bank[~r_bank_sel][r];
                        end
                    end
                end
                ST_COPY: begin
                    // r_bank_sel already points at the new active bank here.
                    for (int r = 0; r < NUM_ROWS; r++) begin
                        if (r_copy_idx == NUM_ROWS_WIDTH'(r)) begin
                            r_bank[~r_bank_sel][r] <= r_bank[r_bank_sel][r];
                        end
                    end
                    if (r_copy_idx == LP_LAST) begin
                        r_state    <= ST_IDLE;
                        r_wr_ready <= 1'b1;
                    end else begin
                        r_copy_idx <= r_copy_idx + NUM_ROWS_WIDTH'(1);
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_wr_ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_wr_ready       = r_wr_ready;
    assign o_wr_err         = r_wr_err;
    assign o_commit_pending = r_pending;
    assign o_swap           = r_swap;
    assign o_rows           = r_rows;

endmodule

// File: tb/tb_led_frame_ctrl.sv
// Directed bench for led_frame_ctrl: a vector table for the frame sequences
// plus hand-written reset, idle-sync and mid-operation reset sequences.
module tb_led_frame_ctrl;

    localparam int NR = 4;
    localparam int NW = 3;
    localparam int NC = 8;

    localparam logic [31:0] F1 = 32'hAACCF00F;
    localparam logic [31:0] F2 = 32'hAA3CF00F;
    localparam logic [31:0] F3 = 32'hAA3C810F;
    localparam logic [31:0] F4 = 32'hAA3C8166;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_wr_valid;
    logic          o_wr_ready;
    logic [NW-1:0] i_wr_row;
    logic [NC-1:0] i_wr_data;
    logic          o_wr_err;
    logic          i_commit;
    logic          o_commit_pending;
    logic          i_frame_sync;
    logic          o_swap;
    logic [NR*NC-1:0] o_rows;

    led_frame_ctrl #(.NUM_ROWS(NR), .NUM_ROWS_WIDTH(NW), .NUM_COLS(NC)) dut (
        .clk              (clk),
        .i_rst            (i_rst),
        .i_wr_valid       (i_wr_valid),
        .o_wr_ready       (o_wr_ready),
        .i_wr_row         (i_wr_row),
        .i_wr_data        (i_wr_data),
        .o_wr_err         (o_wr_err),
        .i_commit         (i_commit),
        .o_commit_pending (o_commit_pending),
        .i_frame_sync     (i_frame_sync),
        .o_swap           (o_swap),
        .o_rows           (o_rows)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [2:0]  row;
        logic [7:0]  data;
        logic        commit;
        logic        sync;
        logic        ready;
        logic        err;
        logic        pend;
        logic        swap;
        logic [31:0] rows;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic v, input logic [2:0] row, input logic [7:0] data,
                       input logic commit, input logic sync, input logic ready,
                       input logic err, input logic pend, input logic swap,
                       input logic [31:0] rows);
        vec_t e;
        e.v = v; e.row = row; e.data = data; e.commit = commit; e.sync = sync;
        e.ready = ready; e.err = err; e.pend = pend; e.swap = swap; e.rows = rows;
        tbl.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] row, input logic [7:0] data,
                         input logic commit, input logic sync);
        i_wr_valid = v; i_wr_row = row; i_wr_data = data;
        i_commit = commit; i_frame_sync = sync;
    endtask

    initial begin
        // Basic frame: four rows, commit, sync five cycles later.
        add(1, 0, 8'h0F, 0, 0, 1, 0, 0, 0, 0);
        add(1, 1, 8'hF0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 2, 8'hCC, 0, 0, 1, 0, 0, 0, 0);
        add(1, 3, 8'hAA, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 8'h00, 0, 1, 0, 0, 0, 1, F1);
        for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, F1);
        add(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, F1);
        // Incremental update of row 2, sync right after commit.
        add(1, 2, 8'h3C, 0, 0, 1, 0, 0, 0, F1);
        add(0, 0, 8'h00, 1, 0, 0, 0, 1, 0, F1);
        add(0, 0, 8'h00, 0, 1, 0, 0, 0, 1, F2);
        for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, F2);
        add(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, F2);
        // Write + commit + sync in one IDLE cycle: write included, sync ignored.
        add(1, 1, 8'h81, 1, 1, 0, 0, 1, 0, F2);
        add(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, F2);
        add(0, 0, 8'h00, 0, 1, 0, 0, 0, 1, F3);
        for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, F3);
        add(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, F3);
        // Out-of-range row 5 is dropped with an error pulse.
        add(1, 5, 8'hFF, 0, 0, 1, 1, 0, 0, F3);
        add(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, F3);
        add(0, 0, 8'h00, 1, 0, 0, 0, 1, 0, F3);
        add(0, 0, 8'h00, 0, 1, 0, 0, 0, 1, F3);
        for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, F3);
        add(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, F3);
        // Write held through PENDING and COPY, taken only once ready returns.
        add(0, 0, 8'h00, 1, 0, 0, 0, 1, 0, F3);
        add(1, 0, 8'h66, 0, 0, 0, 0, 1, 0, F3);
        add(1, 0, 8'h66, 0, 1, 0, 0, 0, 1, F3);
        for (int i = 0; i < 3; i++) add(1, 0, 8'h66, 0, 0, 0, 0, 0, 0, F3);
        add(1, 0, 8'h66, 0, 0, 1, 0, 0, 0, F3);
        add(1, 0, 8'h66, 0, 0, 1, 0, 0, 0, F3);
        add(0, 0, 8'h00, 1, 0, 0, 0, 1, 0, F3);
        add(0, 0, 8'h00, 0, 1, 0, 0, 0, 1, F4);
        for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, F4);
        add(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, F4);

        // Reset held for three cycles.
        drive(0, 0, 8'h00, 0, 0);
        i_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst%0d.rows", i), o_rows, 32'h0);
            chk($sformatf("rst%0d.ready", i), {31'b0, o_wr_ready}, 32'h0);
            chk($sformatf("rst%0d.swap", i), {31'b0, o_swap}, 32'h0);
        end
        i_rst = 1'b1;
        tick();
        chk("rst_rel.ready", {31'b0, o_wr_ready}, 32'h1);
        chk("rst_rel.pend", {31'b0, o_commit_pending}, 32'h0);
        chk("rst_rel.err", {31'b0, o_wr_err}, 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].row, tbl[i].data, tbl[i].commit, tbl[i].sync);
            tick();
            chk($sformatf("vec%0d.ready", i), {31'b0, o_wr_ready}, {31'b0, tbl[i].ready});
            chk($sformatf("vec%0d.err", i), {31'b0, o_wr_err}, {31'b0, tbl[i].err});
            chk($sformatf("vec%0d.pend", i), {31'b0, o_commit_pending}, {31'b0, tbl[i].pend});
            chk($sformatf("vec%0d.swap", i), {31'b0, o_swap}, {31'b0, tbl[i].swap});
            chk($sformatf("vec%0d.rows", i), o_rows, tbl[i].rows);
        end

        // Sync without commit: nothing moves.
        drive(0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("idle_sync%0d.swap", i), {31'b0, o_swap}, 32'h0);
            chk($sformatf("idle_sync%0d.rows", i), o_rows, F4);
        end

        // Reset during PENDING.
        drive(0, 0, 8'h00, 1, 0);
        tick();
        chk("rp.pend_before", {31'b0, o_commit_pending}, 32'h1);
        drive(0, 0, 8'h00, 0, 0);
        i_rst = 1'b0;
        tick();
        chk("rp.rows", o_rows, 32'h0);
        chk("rp.pend", {31'b0, o_commit_pending}, 32'h0);
        chk("rp.ready", {31'b0, o_wr_ready}, 32'h0);
        i_rst = 1'b1;
        tick();
        chk("rp.ready_rel", {31'b0, o_wr_ready}, 32'h1);
        drive(0, 0, 8'h00, 0, 1);
        tick();
        chk("rp.sync_swap", {31'b0, o_swap}, 32'h0);
        chk("rp.sync_pend", {31'b0, o_commit_pending}, 32'h0);
        chk("rp.sync_rows", o_rows, 32'h0);

        // Reset during COPY.
        drive(1, 0, 8'h11, 0, 0);
        tick();
        drive(0, 0, 8'h00, 1, 0);
        tick();
        drive(0, 0, 8'h00, 0, 1);
        tick();
        chk("rc.swap", {31'b0, o_swap}, 32'h1);
        chk("rc.rows_swapped", o_rows, 32'h00000011);
        drive(0, 0, 8'h00, 0, 0);
        i_rst = 1'b0;
        tick();
        chk("rc.rows", o_rows, 32'h0);
        chk("rc.pend", {31'b0, o_commit_pending}, 32'h0);
        chk("rc.ready", {31'b0, o_wr_ready}, 32'h0);
        i_rst = 1'b1;
        tick();
        chk("rc.ready_rel", {31'b0, o_wr_ready}, 32'h1);
        drive(0, 0, 8'h00, 0, 1);
        tick();
        chk("rc.sync_swap", {31'b0, o_swap}, 32'h0);
        chk("rc.sync_rows", o_rows, 32'h0);
        // A fresh commit shows both banks were cleared.
        drive(0, 0, 8'h00, 1, 0);
        tick();
        drive(0, 0, 8'h00, 0, 1);
        tick();
        chk("rc.clr_swap", {31'b0, o_swap}, 32'h1);
        chk("rc.clr_rows", o_rows, 32'h0);
        drive(0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("rc.clr_ready", {31'b0, o_wr_ready}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_frame_ctrl.md
# led_frame_ctrl

Double-buffered frame controller that sits in front of `led_mux` and supplies its row-pattern inputs. A producer writes rows into a hidden shadow bank over a valid/ready handshake, then requests a commit. The commit swaps shadow and active banks only on a frame-boundary pulse, so the multiplexed display never shows a partially updated frame. After each swap, the controller copies the new active bank into the new shadow bank so incremental updates start from the displayed image.

## Interface

Parameters:
- `NUM_ROWS`, 4, number of display rows (≥2)
- `NUM_ROWS_WIDTH`, 2, width of row index; must satisfy 2^NUM_ROWS_WIDTH ≥ NUM_ROWS
- `NUM_COLS`, 8, bits per row

Ports:
- `clk`  in  1  single system clock
- `i_rst`  in  1  synchronous, active-low reset
- `i_wr_valid`  in  1  row write request
- `o_wr_ready`  out  1  write can be accepted this cycle
- `i_wr_row`  in  NUM_ROWS_WIDTH  target row index
- `i_wr_data`  in  NUM_COLS  row pattern
- `o_wr_err`  out  1  one-cycle pulse: accepted write had `i_wr_row` ≥ NUM_ROWS
- `i_commit`  in  1  request swap at next frame boundary
- `o_commit_pending`  out  1  commit requested, swap not yet done
- `i_frame_sync`  in  1  one-cycle frame-boundary pulse from scan logic
- `o_swap`  out  1  one-cycle pulse on the cycle the banks swap
- `o_rows`  out  NUM_ROWS*NUM_COLS  active bank; row r at bits [r*NUM_COLS +: NUM_COLS], drives led_mux `i_rows[r]`

## Operation

- Storage: two banks of NUM_ROWS×NUM_COLS bits. `bank_sel` selects the active bank; the other bank is the shadow.
- All outputs are registered.
- States:
  - IDLE: `o_wr_ready`=1.
    - A write is accepted when `i_wr_valid`&&`o_wr_ready`. It writes `i_wr_data` to shadow row `i_wr_row`.
    - An out-of-range row is dropped and `o_wr_err` pulses on the next cycle.
    - `i_commit`=1 → PENDING. A write accepted in the same cycle as the commit is included in the committed frame.
    - `i_frame_sync` is ignored.
  - PENDING: `o_wr_ready`=0, `o_commit_pending`=1.
    - On an edge with `i_frame_sync`=1, `bank_sel` toggles, `o_swap` pulses, and the state goes to COPY.
    - Further `i_commit` is ignored.
    - If `i_commit` and `i_frame_sync` are both 1 in IDLE, the commit is taken and the sync is ignored. The swap waits for the next sync.
  - COPY: `o_wr_ready`=0, `o_commit_pending`=0.
    - Copies one row per cycle, new active → new shadow, for rows 0..NUM_ROWS-1. This takes exactly NUM_ROWS cycles, then the state returns to IDLE.
    - `i_frame_sync` and `i_commit` are ignored.
- Writes are never lost silently. A write offered while `o_wr_ready`=0 is not accepted; the producer holds `i_wr_valid` and its data.
- Reset (`i_rst`=0 at an edge), including mid-PENDING or mid-COPY:
  - State → IDLE and `bank_sel`=0.
  - Both banks are cleared to 0.
  - Any pending commit is discarded.

## Timing

- Reset values: `o_rows`=0, `o_wr_ready`=0 while `i_rst`=0. `o_wr_ready`=1 from the first edge with `i_rst`=1. `o_wr_err`, `o_commit_pending` and `o_swap` are all 0.
- Write → shadow: updated at the accepting edge. Not visible on `o_rows` until a swap.
- Commit → pending: `o_commit_pending`=1 starting the cycle after the commit edge. `o_wr_ready` drops in the same cycle.
- Swap: on the PENDING edge with `i_frame_sync`=1, the following all change together for the next cycle: `o_rows` shows the new bank, `o_swap`=1, `o_commit_pending`=0.
- Minimum latency from commit edge to `o_rows` update is 2 edges, which happens when sync arrives the cycle after the commit.
- COPY occupies NUM_ROWS cycles after the swap edge. `o_wr_ready` returns to 1 on the cycle after the last copy.
- Back-to-back: a commit issued on the first IDLE cycle after COPY is accepted normally.
- `o_rows` is stable between swap edges. It never changes outside a swap or reset.

## Test plan

All scenarios use NUM_ROWS=4 and NUM_COLS=8.

- **Reset:** hold `i_rst`=0 for 3 cycles → `o_rows`=0, `o_wr_ready`=0, no `o_swap`. Release → `o_wr_ready`=1 on the next cycle.
- **Basic frame:**
  - Stimulus: write rows 0..3 = 0x0F, 0xF0, 0xCC, 0xAA; commit; pulse `i_frame_sync` 5 cycles later.
  - Response: `o_rows` stays 0 until the sync edge, then equals {0xAA,0xCC,0xF0,0x0F}. `o_swap` pulses once. `o_wr_ready` is low for exactly 4 cycles after the swap.
- **Incremental update:**
  - Stimulus: after the basic frame, write only row 2 = 0x3C, commit, sync.
  - Response: `o_rows`={0xAA,0x3C,0xF0,0x0F}, which proves the COPY stage worked.
- **Blocking and boundary:**
  - Writes are held while PENDING and not accepted until after COPY ends.
  - A write to row 5 pulses `o_wr_err` and leaves all rows unchanged.
  - A write plus commit in the same cycle includes that write.
  - Commit and sync in the same IDLE cycle → no swap until the next sync.
- **Sync without commit:** pulse `i_frame_sync` 10 times in IDLE → `o_rows` is unchanged and `o_swap` stays 0.
- **Reset mid-operation:**
  - Stimulus: assert `i_rst`=0 for one edge during PENDING, and again during COPY.
  - Response: state returns to IDLE, `o_rows`=0, `o_commit_pending`=0, and a later sync causes no swap.
